// File: rtl/ropuf_pkg.sv
// Shared types and constants for the RO-PUF response datapath.
package ropuf_pkg;

  localparam int RESP_WIDTH = 256;

  typedef enum logic {
    RC_COLLECT = 1'b0,
    RC_FULL    = 1'b1
  } rc_state_t;

endpackage

// File: rtl/response_collector.sv
// Serial-in/parallel-out response collector: gathers LANE-bit beats into a
// WIDTH-bit word and hands the completed word downstream under valid/ready.
module response_collector
  import ropuf_pkg::*;
#(
  parameter int WIDTH     = RESP_WIDTH,
  parameter int LANE      = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic [LANE-1:0]                     s_in,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [WIDTH-1:0]                    p_out,
  output logic                                p_valid,
  input  logic                                p_ready,
  output logic [$clog2(WIDTH/LANE+1)-1:0]     count
);

  localparam int BEATS = WIDTH / LANE;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(BEATS);

  rc_state_t        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic [WIDTH-1:0] shift_word;

  generate
    if ((WIDTH % LANE != 0) || !(LANE == 1 || LANE == 2 || LANE == 4 || LANE == 8)) begin : g_bad_params
      $fatal(1, "response_collector: WIDTH must be a multiple of LANE and LANE one of 1,2,4,8");
    end

    // A single-beat word has nothing to shift; the beat is the whole word.
    if (WIDTH == LANE) begin : g_single
      assign shift_word = s_in;
    end else if (MSB_FIRST == 0) begin : g_enter_top
      assign shift_word = {s_in, p_out_q[WIDTH-1:LANE]};
    end else begin : g_enter_bottom
      assign shift_word = {p_out_q[WIDTH-LANE-1:0], s_in};
    end
  endgenerate

  // Next-state, fill level and word assembly; clear dominates accept and p_ready.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_out_d = p_out_q;
    if (clear) begin
      state_d = RC_COLLECT;
      count_d = '0;
      p_out_d = '0;
    end else begin
      case (state_q)
        RC_COLLECT: begin
          if (s_valid) begin
            p_out_d = shift_word;
            if (count_q == LAST_BEAT) begin
              count_d = FULL_CNT;
              state_d = RC_FULL;
            end else begin
              count_d = count_q + CW'(1);
            end
          end else begin
            p_out_d = p_out_q;
          end
        end
        RC_FULL: begin
          if (p_ready) begin
            state_d = RC_COLLECT;
            count_d = '0;
          end else begin
            state_d = RC_FULL;
          end
        end
        default: begin
          state_d = RC_COLLECT;
          count_d = '0;
        end
      endcase
    end
  end

  // State, count and word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RC_COLLECT;
      count_q <= '0;
      p_out_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_out_q <= p_out_d;
    end
  end

  assign s_ready = (state_q == RC_COLLECT);
  assign p_valid = (state_q == RC_FULL);
  assign p_out   = p_out_q;
  assign count   = count_q;

endmodule
